pea_result_reader: RTL and testbench

- Host-side consumer of the PEA output path. It drains the result and status output FIFOs in lockstep, pairing entry k of one with entry k of the other.
- Each pair is presented to the host on a valid/ready interface.
- It tracks the number of delivered pairs and flags result/status desynchronisation.
- It sits between the two 32-deep output FIFOs and the host or bench collector, replacing hand-driven rd_en_result/rd_en_status pulses.

---
 rtl/pea_pkg.sv | 34 +++
 rtl/pea_result_reader_if.sv | 32 +++
 rtl/pea_desync_monitor.sv | 64 ++++++
 rtl/pea_result_reader.sv | 118 +++++++++++
 tb/tb_pea_result_reader.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pea_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pea_pkg
// Shared definitions for the PEA host-side blocks:
//   - reader_state_t : state encoding of the result/status reader FSM
//   - SETUP_INSTR / INSTR / OUTPUT : PEA operating mode constants
//   - log2_ceil()    : constant-context log2 used to size population counts
// ---------------------------------------------------------------------------
package pea_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        PRESENT = 2'd3
    } reader_state_t;

    localparam logic [1:0] SETUP_INSTR = 2'b00;
    localparam logic [1:0] INSTR       = 2'b01;
    localparam logic [1:0] OUTPUT      = 2'b10;

    // Smallest r such that 2**r >= value (0 for value <= 1).
    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pea_result_reader_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pea_result_reader_if
// Host-side valid/ready channel carrying one result/status pair.
//   out_valid  : a pair is held on out_result/out_status
//   out_ready  : host accepts the pair
//   out_result : held result word
//   out_status : held status word
// Modports: master = reader (drives the pair), slave = host (drives ready).
// ---------------------------------------------------------------------------
interface pea_result_reader_if #(
    parameter int WIDTH = 32
) ();
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [WIDTH-1:0] out_status;

    modport master (
        output out_valid,
        output out_result,
        output out_status,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_result,
        input  out_status,
        output out_ready
    );
endinterface

// File: rtl/pea_desync_monitor.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pea_desync_monitor
// Watches the result and status FIFO populations. While exactly one of them
// is empty a timeout counter runs (saturating at TIMEOUT); when it reaches
// TIMEOUT the sticky desync flag is raised until clear or reset.
// Ports:
//   clk, rst (async, active low)
//   result_pop, status_pop : FIFO population counts
//   clear                  : synchronous clear of counter and flag
//   desync                 : sticky out-of-step flag
// ---------------------------------------------------------------------------
module pea_desync_monitor
    import pea_pkg::*;
#(
    parameter int POP_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [POP_W-1:0] result_pop,
    input  logic [POP_W-1:0] status_pop,
    input  logic             clear,
    output logic             desync
);
    localparam int TO_W = log2_ceil(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);

    logic [TO_W-1:0] timeout_cnt_reg;
    logic [TO_W-1:0] timeout_cnt_next;
    logic            desync_reg;
    logic            desync_next;
    logic            one_sided;

    always_comb begin
        one_sided        = (result_pop == '0) != (status_pop == '0);
        timeout_cnt_next = '0;
        desync_next      = desync_reg;
        if (clear) begin
            timeout_cnt_next = '0;
            desync_next      = 1'b0;
        end else begin
            if (one_sided) begin
                timeout_cnt_next = (timeout_cnt_reg == TIMEOUT_C) ?
                                   timeout_cnt_reg : timeout_cnt_reg + 1'b1;
            end
            // Flag rises on the same edge the counter reaches TIMEOUT.
            desync_next = desync_reg | (timeout_cnt_next == TIMEOUT_C);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_cnt_reg <= '0;
            desync_reg      <= 1'b0;
        end else begin
            timeout_cnt_reg <= timeout_cnt_next;
            desync_reg      <= desync_next;
        end
    end

    assign desync = desync_reg;

endmodule

// File: rtl/pea_result_reader.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pea_result_reader
// Drains the PEA result and status output FIFOs in lockstep and presents
// each result/status pair on a valid/ready host channel.
// Ports:
//   clk, rst (async, active low)
//   enable                      : allows new pops (in-flight pair completes)
//   result_pop / status_pop     : FIFO population counts
//   result_fifo_data / status_fifo_data : FIFO read data (one cycle after rd_en)
//   rd_en_result / rd_en_status : FIFO read strobes, always pulsed together
//   host (master)               : out_valid/out_ready/out_result/out_status
//   pair_count                  : pairs accepted by the host (saturating)
//   desync                      : sticky FIFO out-of-step flag
//   clear                       : synchronous clear of pair_count and desync
// ---------------------------------------------------------------------------
module pea_result_reader
    import pea_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int BUFFER_SIZE_OUT = 32,
    parameter int POP_W           = log2_ceil(BUFFER_SIZE_OUT),
    parameter int TIMEOUT         = 16,
    parameter int CNT_W           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [POP_W-1:0]     result_pop,
    input  logic [POP_W-1:0]     status_pop,
    input  logic [WIDTH-1:0]     result_fifo_data,
    input  logic [WIDTH-1:0]     status_fifo_data,
    output logic                 rd_en_result,
    output logic                 rd_en_status,
    pea_result_reader_if.master  host,
    output logic [CNT_W-1:0]     pair_count,
    output logic                 desync,
    input  logic                 clear
);
    reader_state_t    state_reg;
    logic             rd_en_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_result_reg;
    logic [WIDTH-1:0] out_status_reg;
    logic [CNT_W-1:0] pair_count_reg;
    logic             handshake;

    assign handshake = out_valid_reg && host.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            rd_en_reg      <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            out_status_reg <= '0;
            pair_count_reg <= '0;
        end else begin
            rd_en_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (enable && (result_pop != '0) && (status_pop != '0)) begin
                        rd_en_reg <= 1'b1;
                        state_reg <= WAIT;
                    end
                end
                // Strobe is high during this state; the FIFOs present data
                // after the edge that ends it.
                WAIT: begin
                    state_reg <= CAPTURE;
                end
                CAPTURE: begin
                    out_result_reg <= result_fifo_data;
                    out_status_reg <= status_fifo_data;
                    out_valid_reg  <= 1'b1;
                    state_reg      <= PRESENT;
                end
                PRESENT: begin
                    if (host.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            // clear takes priority over a coincident handshake.
            if (clear) begin
                pair_count_reg <= '0;
            end else if (handshake && (pair_count_reg != '1)) begin
                pair_count_reg <= pair_count_reg + 1'b1;
            end
        end
    end

    // A single register drives both strobes so a one-sided pop cannot occur.
    assign rd_en_result    = rd_en_reg;
    assign rd_en_status    = rd_en_reg;
    assign host.out_valid  = out_valid_reg;
    assign host.out_result = out_result_reg;
    assign host.out_status = out_status_reg;
    assign pair_count      = pair_count_reg;

    pea_desync_monitor #(
        .POP_W   (POP_W),
        .TIMEOUT (TIMEOUT)
    ) u_desync_monitor (
        .clk        (clk),
        .rst        (rst),
        .result_pop (result_pop),
        .status_pop (status_pop),
        .clear      (clear),
        .desync     (desync)
    );

endmodule

// File: tb/tb_pea_result_reader.sv
`timescale 1ns/1ps
module tb_pea_result_reader;
    import pea_pkg::*;

    localparam int WIDTH = 32;
    localparam int POP_W = 5;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             enable;
    logic             clear;
    logic [POP_W-1:0] result_pop;
    logic [POP_W-1:0] status_pop;
    logic [WIDTH-1:0] result_fifo_data;
    logic [WIDTH-1:0] status_fifo_data;
    logic             rd_en_result;
    logic             rd_en_status;
    logic [CNT_W-1:0] pair_count;
    logic             desync;

    pea_result_reader_if #(.WIDTH(WIDTH)) host ();

    pea_result_reader #(
        .WIDTH(WIDTH), .BUFFER_SIZE_OUT(32), .POP_W(POP_W), .TIMEOUT(16), .CNT_W(CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .result_pop       (result_pop),
        .status_pop       (status_pop),
        .result_fifo_data (result_fifo_data),
        .status_fifo_data (status_fifo_data),
        .rd_en_result     (rd_en_result),
        .rd_en_status     (rd_en_status),
        .host             (host),
        .pair_count       (pair_count),
        .desync           (desync),
        .clear            (clear)
    );

    // FIFO models: registered read, data appears the cycle after rd_en.
    logic [WIDTH-1:0] rmem [64];
    logic [WIDTH-1:0] smem [64];
    int r_wr = 0, r_rd = 0, s_wr = 0, s_rd = 0;
    int rd_pulses = 0;

    assign result_pop = POP_W'(r_wr - r_rd);
    assign status_pop = POP_W'(s_wr - s_rd);

    always @(posedge clk) begin
        if (rd_en_result) begin
            result_fifo_data <= rmem[r_rd % 64];
            r_rd             <= r_rd + 1;
            rd_pulses        <= rd_pulses + 1;
        end
        if (rd_en_status) begin
            status_fifo_data <= smem[s_rd % 64];
            s_rd             <= s_rd + 1;
        end
    end

    logic [63:0] exp_q [$];
    int tests = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_pair(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] s);
        rmem[r_wr % 64] = r;
        r_wr++;
        smem[s_wr % 64] = s;
        s_wr++;
        exp_q.push_back({r, s});
    endtask

    task automatic wait_drain(input string name, input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || host.out_valid) && n < max) begin
            tick(1);
            n++;
        end
        check(name, 64'(n < max), 64'd1);
    endtask

    task automatic wait_valid(input string name, input int max);
        int n;
        n = 0;
        while (!host.out_valid && n < max) begin
            tick(1);
            n++;
        end
        check(name, 64'(n < max), 64'd1);
    endtask

    task automatic wait_rd(input string name, input int max);
        int n;
        n = 0;
        while (!rd_en_result && n < max) begin
            tick(1);
            n++;
        end
        check(name, 64'(n < max), 64'd1);
    endtask

    // Monitor: checks strobe lockstep, stall stability and pops the scoreboard
    // on every handshake.
    initial begin
        logic             hold;
        logic [WIDTH-1:0] pr;
        logic [WIDTH-1:0] ps;
        logic [63:0]      e;
        hold = 1'b0;
        pr = '0;
        ps = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && (rd_en_result || rd_en_status))
                check("rd_en_lockstep", 64'(rd_en_result), 64'(rd_en_status));
            if (host.out_valid === 1'b1) begin
                if (hold) begin
                    check("stall_result", 64'(host.out_result), 64'(pr));
                    check("stall_status", 64'(host.out_status), 64'(ps));
                end
                if (host.out_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        failures++;
                        $display("[TB] FAIL unexpected_pair: got result=0x%0h status=0x%0h, expected none",
                                 host.out_result, host.out_status);
                    end else begin
                        e = exp_q.pop_front();
                        check("pair_result", 64'(host.out_result), 64'(e[63:32]));
                        check("pair_status", 64'(host.out_status), 64'(e[31:0]));
                        $display("[TB] pair delivered result=0x%08h status=0x%08h",
                                 host.out_result, host.out_status);
                    end
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    pr   = host.out_result;
                    ps   = host.out_status;
                end
            end else begin
                hold = 1'b0;
            end
        end
    end

    initial begin
        int p0;
        rst = 1'b1;
        enable = 1'b0;
        clear = 1'b0;
        host.out_ready = 1'b0;
        #2 rst = 1'b0;
        tick(2);
        check("reset_out_valid", 64'(host.out_valid), 64'd0);
        check("reset_rd_en_result", 64'(rd_en_result), 64'd0);
        check("reset_rd_en_status", 64'(rd_en_status), 64'd0);
        check("reset_pair_count", 64'(pair_count), 64'd0);
        check("reset_desync", 64'(desync), 64'd0);
        check("reset_out_result", 64'(host.out_result), 64'd0);
        check("reset_out_status", 64'(host.out_status), 64'd0);
        rst = 1'b1;
        tick(1);

        // Single pair, latency check.
        enable = 1'b1;
        host.out_ready = 1'b1;
        p0 = rd_pulses;
        load_pair(32'h0000_002A, 32'h0000_0001);
        tick(1);
        check("t1_rd_en_result", 64'(rd_en_result), 64'd1);
        check("t1_rd_en_status", 64'(rd_en_status), 64'd1);
        tick(1);
        check("t1_rd_en_low", 64'(rd_en_result), 64'd0);
        check("t1_not_valid_yet", 64'(host.out_valid), 64'd0);
        tick(1);
        check("t1_valid_at_3", 64'(host.out_valid), 64'd1);
        check("t1_out_result", 64'(host.out_result), 64'd42);
        check("t1_out_status", 64'(host.out_status), 64'd1);
        tick(1);
        check("t1_pair_count", 64'(pair_count), 64'd1);
        check("t1_valid_cleared", 64'(host.out_valid), 64'd0);
        check("t1_rd_pulses", 64'(rd_pulses - p0), 64'd1);

        // Four pairs with a 10-cycle host stall.
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("t2_cleared_count", 64'(pair_count), 64'd0);
        host.out_ready = 1'b0;
        p0 = rd_pulses;
        for (int i = 0; i < 4; i++) load_pair(32'h100 + i, 32'h200 + i);
        tick(10);
        check("t2_stall_rd_pulses", 64'(rd_pulses - p0), 64'd1);
        check("t2_stall_valid", 64'(host.out_valid), 64'd1);
        host.out_ready = 1'b1;
        wait_drain("t2_drain_timeout", 60);
        check("t2_pair_count", 64'(pair_count), 64'd4);
        check("t2_rd_pulses", 64'(rd_pulses - p0), 64'd4);

        // One-sided FIFO: desync after 16 cycles, no pops.
        p0 = rd_pulses;
        rmem[r_wr % 64] = 32'hDEAD_0001;
        r_wr++;
        tick(15);
        check("t3_desync_15", 64'(desync), 64'd0);
        tick(1);
        check("t3_desync_16", 64'(desync), 64'd1);
        check("t3_no_pops", 64'(rd_pulses - p0), 64'd0);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("t3_desync_cleared", 64'(desync), 64'd0);
        smem[s_wr % 64] = 32'h0000_0005;
        s_wr++;
        exp_q.push_back({32'hDEAD_0001, 32'h0000_0005});
        wait_drain("t3_drain_timeout", 30);
        check("t3_pair_count", 64'(pair_count), 64'd1);
        check("t3_desync_still_low", 64'(desync), 64'd0);

        // enable dropped after the strobe: pair completes, no further pops.
        p0 = rd_pulses;
        for (int i = 0; i < 3; i++) load_pair(32'h300 + i, 32'h400 + i);
        wait_rd("t4_rd_timeout", 20);
        tick(1);
        enable = 1'b0;
        tick(20);
        check("t4_rd_pulses", 64'(rd_pulses - p0), 64'd1);
        check("t4_remaining", 64'(exp_q.size()), 64'd2);
        check("t4_pair_count", 64'(pair_count), 64'd2);
        enable = 1'b1;
        wait_drain("t4_drain_timeout", 40);
        check("t4_pair_count_final", 64'(pair_count), 64'd4);

        // Asynchronous reset during PRESENT drops the held pair.
        host.out_ready = 1'b0;
        load_pair(32'h77, 32'h78);
        wait_valid("t5_valid_timeout", 20);
        tick(2);
        rst = 1'b0;
        #1;
        check("t5_async_valid", 64'(host.out_valid), 64'd0);
        check("t5_async_count", 64'(pair_count), 64'd0);
        check("t5_async_rd_en", 64'(rd_en_result), 64'd0);
        exp_q.delete();
        tick(1);
        rst = 1'b1;
        tick(1);
        load_pair(32'h99, 32'h9A);
        host.out_ready = 1'b1;
        wait_drain("t5_drain_timeout", 30);
        check("t5_pair_count", 64'(pair_count), 64'd1);

        // clear coincident with a handshake at pair_count = 7.
        for (int i = 0; i < 6; i++) load_pair(32'h500 + i, 32'h600 + i);
        wait_drain("t6_drain_timeout", 100);
        check("t6_pair_count_7", 64'(pair_count), 64'd7);
        host.out_ready = 1'b0;
        load_pair(32'hABCD, 32'hEF01);
        wait_valid("t6_valid_timeout", 20);
        host.out_ready = 1'b1;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("t6_clear_wins", 64'(pair_count), 64'd0);
        check("t6_valid_cleared", 64'(host.out_valid), 64'd0);
        tick(2);
        check("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
